// File: rtl/floo_test_sched_pkg.sv
// Shared types and defaults for the DMA test-node launch scheduler.
package floo_test_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DRAIN,
    DONE,
    TIMEOUT
  } sched_state_e;

  localparam int unsigned DefaultDrainCycles   = 1024;
  localparam int unsigned DefaultStaggerCycles = 16;

endpackage

// File: rtl/floo_sched_next_node.sv
// Picks the lowest-indexed masked node that has not been launched yet (one-hot).
module floo_sched_next_node #(
  parameter int unsigned NumNodes = 2
) (
  input  logic [NumNodes-1:0] mask,
  input  logic [NumNodes-1:0] launched,
  output logic [NumNodes-1:0] pick,
  output logic                valid
);

  logic [NumNodes-1:0] pending;

  assign pending = mask & ~launched;
  // Two's-complement trick isolates the lowest set bit.
  assign pick    = pending & (~pending + NumNodes'(1));
  assign valid   = |pending;

endmodule

// File: rtl/floo_test_node_scheduler.sv
// Launch sequencer and end-of-simulation controller for the tile's DMA test nodes.
// Optional WAIT-state watchdog is built in when FLOO_SCHED_WATCHDOG_EN is defined.
module floo_test_node_scheduler
  import floo_test_sched_pkg::*;
#(
  parameter int unsigned NumNodes       = 2,
  parameter int unsigned StaggerCycles  = DefaultStaggerCycles,
  parameter int unsigned DrainCycles    = DefaultDrainCycles,
`ifdef FLOO_SCHED_WATCHDOG_EN
  parameter int unsigned WatchdogCycles = 1000000,
`endif
  parameter int unsigned CntWidth       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                seq_mode_i,
  input  logic [NumNodes-1:0] node_mask_i,
  output logic [NumNodes-1:0] node_start_o,
  input  logic [NumNodes-1:0] node_done_i,
  output logic                busy_o,
  output logic                end_of_sim_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] run_cycles_o
);

  localparam int unsigned StgW   = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
  localparam int unsigned DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
`ifdef FLOO_SCHED_WATCHDOG_EN
  localparam int unsigned WdW    = (WatchdogCycles > 1) ? $clog2(WatchdogCycles) : 1;
`endif

  sched_state_e        state_q, state_d;
  logic [NumNodes-1:0] mask_q, launched_q, last_pick_q;
  logic                seq_q, seq_go_q;
  logic [StgW-1:0]     stagger_q;
  logic [DrainW-1:0]   drain_q;
  logic [CntWidth-1:0] run_q;
`ifdef FLOO_SCHED_WATCHDOG_EN
  logic [WdW-1:0]      wd_q;
  logic [NumNodes-1:0] done_seen_q;
`endif

  logic [NumNodes-1:0] pick, launch_set, done_q;
  logic                pick_valid, launch_ok, all_done;

  floo_sched_next_node #(
    .NumNodes (NumNodes)
  ) i_next_node (
    .mask     (mask_q),
    .launched (launched_q),
    .pick     (pick),
    .valid    (pick_valid)
  );

  // A done only counts once the node's launch is registered, so a same-cycle done is ignored.
  assign done_q   = node_done_i & launched_q;
  assign all_done = (done_q == mask_q);

  // With zero stagger in concurrent mode every remaining node goes at once.
  assign launch_set = (!seq_q && (StaggerCycles == 0)) ? (mask_q & ~launched_q) : pick;

  always_comb begin
    launch_ok = 1'b0;
    if ((state_q == LAUNCH) && pick_valid) begin
      if (seq_q) begin
        launch_ok = (launched_q == '0) || seq_go_q;
      end else begin
        launch_ok = (stagger_q == '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = LAUNCH;
      LAUNCH:  if (!pick_valid) state_d = WAIT;
      WAIT: begin
        if (all_done) begin
          state_d = DRAIN;
        end
`ifdef FLOO_SCHED_WATCHDOG_EN
        else if (wd_q == WdW'(WatchdogCycles - 1)) begin
          state_d = TIMEOUT;
        end
`endif
      end
      DRAIN:   if (drain_q == DrainW'(DrainCycles - 1)) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q      <= '0;
      seq_q       <= 1'b0;
      launched_q  <= '0;
      last_pick_q <= '0;
      seq_go_q    <= 1'b0;
      stagger_q   <= '0;
      drain_q     <= '0;
      run_q       <= '0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        mask_q <= node_mask_i;
        seq_q  <= seq_mode_i;
      end
      if (launch_ok) begin
        launched_q  <= launched_q | launch_set;
        last_pick_q <= pick;
        stagger_q   <= (StaggerCycles > 0) ? StgW'(StaggerCycles - 1) : '0;
      end else if (stagger_q != '0) begin
        stagger_q <= stagger_q - StgW'(1);
      end
      // Sequential hand-off is registered, so the next node starts the cycle after the done.
      seq_go_q <= !launch_ok && (state_q == LAUNCH) && |(done_q & last_pick_q);
      if (((state_q == LAUNCH) || (state_q == WAIT)) && (run_q != '1)) begin
        run_q <= run_q + CntWidth'(1);
      end
      if ((state_q == DRAIN) && (state_d == DRAIN)) begin
        drain_q <= drain_q + DrainW'(1);
      end
    end
  end

`ifdef FLOO_SCHED_WATCHDOG_EN
  // Watchdog restarts whenever a node reports done for the first time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q        <= '0;
      done_seen_q <= '0;
    end else if (state_q == WAIT) begin
      done_seen_q <= done_seen_q | done_q;
      if (|(done_q & ~done_seen_q)) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WdW'(1);
      end
    end
  end
`endif

  always_comb begin
    busy_o       = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == DRAIN);
    end_of_sim_o = (state_q == DONE);
    timeout_o    = 1'b0;
`ifdef FLOO_SCHED_WATCHDOG_EN
    end_of_sim_o = (state_q == DONE) || (state_q == TIMEOUT);
    timeout_o    = (state_q == TIMEOUT);
`endif
  end

  assign node_start_o = launched_q;
  assign run_cycles_o = run_q;

endmodule

// File: tb/tb_floo_test_node_scheduler.sv
// Scoreboard bench for floo_test_node_scheduler; covers the watchdog when FLOO_SCHED_WATCHDOG_EN is defined.
module tb_floo_test_node_scheduler;

  localparam int unsigned NumNodes = 2;
  localparam int unsigned Stagger  = 16;
  localparam int unsigned Drain    = 8;
  localparam int unsigned CntWidth = 32;
  localparam int EvStart = 0;
  localparam int EvEos   = 1;
  localparam int EvSnap  = 2;

  typedef struct {
    int          kind;
    int          idx;
    int          cyc;
    logic        busy;
    logic        eos;
    logic        tout;
    logic [1:0]  starts;
    logic [31:0] run;
  } exp_t;

  exp_t sb[$];

  logic                clk_i       = 1'b0;
  logic                rst_ni      = 1'b0;
  logic                start_i     = 1'b0;
  logic                seq_mode_i  = 1'b0;
  logic [NumNodes-1:0] node_mask_i = '0;
  logic [NumNodes-1:0] node_done_i = '0;
  logic [NumNodes-1:0] node_start_o;
  logic                busy_o, end_of_sim_o, timeout_o;
  logic [CntWidth-1:0] run_cycles_o;

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] prev_starts = '0;
  logic       prev_eos    = 1'b0;

  floo_test_node_scheduler #(
    .NumNodes       (NumNodes),
    .StaggerCycles  (Stagger),
    .DrainCycles    (Drain),
`ifdef FLOO_SCHED_WATCHDOG_EN
    .WatchdogCycles (100),
`endif
    .CntWidth       (CntWidth)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .seq_mode_i   (seq_mode_i),
    .node_mask_i  (node_mask_i),
    .node_start_o (node_start_o),
    .node_done_i  (node_done_i),
    .busy_o       (busy_o),
    .end_of_sim_o (end_of_sim_o),
    .timeout_o    (timeout_o),
    .run_cycles_o (run_cycles_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic matchEvent(input int kind, input int idx);
    int found;
    found = -1;
    for (int k = 0; k < sb.size(); k++) begin
      if (found < 0 && sb[k].kind == kind && sb[k].idx == idx) found = k;
    end
    if (found < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event kind=%0d idx=%0d: seen at cycle %0d, expected none", kind, idx, cyc);
    end else begin
      checkOutput($sformatf("event_cycle kind=%0d idx=%0d", kind, idx), cyc, sb[found].cyc);
      if (kind == EvEos) begin
        checkOutput("run_cycles_at_eos", run_cycles_o, sb[found].run);
        checkOutput("timeout_at_eos", timeout_o, sb[found].tout);
        checkOutput("busy_at_eos", busy_o, 0);
      end
      sb.delete(found);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge, matches output events and snapshots.
  always @(posedge clk_i) begin
    #1;
    if (rst_ni) begin
      for (int i = 0; i < NumNodes; i++) begin
        if (node_start_o[i] && !prev_starts[i]) matchEvent(EvStart, i);
        if (!node_start_o[i] && prev_starts[i]) begin
          checks++;
          errors++;
          $display("[TB] FAIL start_fall idx=%0d @cycle %0d: got 0, expected 1", i, cyc);
        end
      end
      if (end_of_sim_o && !prev_eos) matchEvent(EvEos, 0);
      if (!end_of_sim_o && prev_eos) begin
        checks++;
        errors++;
        $display("[TB] FAIL eos_fall @cycle %0d: got 0, expected 1", cyc);
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc <= cyc) begin
        if (sb[k].kind == EvSnap) begin
          checkOutput("snap_busy", busy_o, sb[k].busy);
          checkOutput("snap_eos", end_of_sim_o, sb[k].eos);
          checkOutput("snap_timeout", timeout_o, sb[k].tout);
          checkOutput("snap_node_start", node_start_o, sb[k].starts);
          checkOutput("snap_run_cycles", run_cycles_o, sb[k].run);
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL missed_event kind=%0d idx=%0d: not seen, expected at cycle %0d", sb[k].kind, sb[k].idx, sb[k].cyc);
        end
        sb.delete(k);
      end
    end
    prev_starts = node_start_o;
    prev_eos    = end_of_sim_o;
  end

  task automatic expectStart(input int idx, input int c);
    exp_t e;
    e = '{kind: EvStart, idx: idx, cyc: c, busy: 1'b0, eos: 1'b0, tout: 1'b0, starts: 2'b00, run: 32'd0};
    sb.push_back(e);
  endtask

  task automatic expectEos(input int c, input int run, input logic tout);
    exp_t e;
    e = '{kind: EvEos, idx: 0, cyc: c, busy: 1'b0, eos: 1'b1, tout: tout, starts: 2'b00, run: run};
    sb.push_back(e);
  endtask

  task automatic expectSnap(input int c, input logic busy, input logic eos, input logic tout,
                            input logic [1:0] starts, input int run);
    exp_t e;
    e = '{kind: EvSnap, idx: 0, cyc: c, busy: busy, eos: eos, tout: tout, starts: starts, run: run};
    sb.push_back(e);
  endtask

  // Returns at the falling edge that follows rising edge number k.
  task automatic waitEdge(input int k);
    @(negedge clk_i);
    while (cyc < k) @(negedge clk_i);
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge clk_i);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    node_done_i = '0;
    expectSnap(cyc + 1, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Issues one start pulse; t is the rising edge that accepts it.
  task automatic applyStimulus(input logic mode, input logic [1:0] mask, output int t);
    @(negedge clk_i);
    seq_mode_i  = mode;
    node_mask_i = mask;
    start_i     = 1'b1;
    t           = cyc + 1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic runConcurrentBoth();
    int t;
    applyStimulus(1'b0, 2'b11, t);
    expectStart(0, t + 1);
    expectStart(1, t + 17);
    expectSnap(t + 25, 1'b1, 1'b0, 1'b0, 2'b11, 25);
    expectSnap(t + 64, 1'b1, 1'b0, 1'b0, 2'b11, 60);
    expectEos(t + 68, 60, 1'b0);
    waitEdge(t + 39);
    node_done_i[0] = 1'b1;
    waitEdge(t + 59);
    node_done_i[1] = 1'b1;
    waitIdle();
  endtask

  initial begin
    int t;
    expectSnap(2, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] concurrent, mask 11");
    runConcurrentBoth();
    applyStimulus(1'b0, 2'b11, t);
    expectSnap(t + 10, 1'b0, 1'b1, 1'b0, 2'b11, 60);
    waitIdle();

    $display("[TB] sequential, mask 11, early done on node 1");
    doReset();
    applyStimulus(1'b1, 2'b11, t);
    expectStart(0, t + 1);
    expectSnap(t + 20, 1'b1, 1'b0, 1'b0, 2'b01, 20);
    expectStart(1, t + 31);
    expectEos(t + 41, 33, 1'b0);
    waitEdge(t + 9);
    node_done_i[1] = 1'b1;
    waitEdge(t + 29);
    node_done_i[0] = 1'b1;
    waitIdle();

    $display("[TB] empty mask");
    doReset();
    applyStimulus(1'b0, 2'b00, t);
    expectSnap(t + 5, 1'b1, 1'b0, 1'b0, 2'b00, 2);
    expectEos(t + 10, 2, 1'b0);
    waitIdle();

    $display("[TB] mask 10, done on unmasked node 0");
    doReset();
    node_done_i[0] = 1'b1;
    applyStimulus(1'b0, 2'b10, t);
    expectStart(1, t + 1);
    expectSnap(t + 10, 1'b1, 1'b0, 1'b0, 2'b10, 10);
    expectEos(t + 28, 20, 1'b0);
    waitEdge(t + 19);
    node_done_i[1] = 1'b1;
    waitIdle();

    $display("[TB] reset during WAIT, then rerun");
    doReset();
    applyStimulus(1'b0, 2'b11, t);
    expectStart(0, t + 1);
    expectStart(1, t + 17);
    waitEdge(t + 29);
    node_done_i[0] = 1'b1;
    waitEdge(t + 35);
    waitIdle();
    doReset();
    runConcurrentBoth();

`ifdef FLOO_SCHED_WATCHDOG_EN
    $display("[TB] watchdog expiry");
    doReset();
    applyStimulus(1'b0, 2'b01, t);
    expectStart(0, t + 1);
    expectSnap(t + 50, 1'b1, 1'b0, 1'b0, 2'b01, 50);
    expectEos(t + 102, 102, 1'b1);
    waitIdle();
`else
    $display("[TB] no watchdog: done never arrives");
    doReset();
    applyStimulus(1'b0, 2'b01, t);
    expectStart(0, t + 1);
    expectSnap(t + 150, 1'b1, 1'b0, 1'b0, 2'b01, 150);
    waitIdle();
`endif

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
